// File: rtl/maze_player_ctrl.sv
// Player-movement controller for the maze game.
// Takes one-hot direction requests, checks the target cell against the grid
// edges and the wall bitmap, and moves the player one cell per request.
// Adds press edge detection, optional hold-to-repeat, goal detection,
// a saturating move counter and one-cycle move/wall-bump pulses.
module maze_player_ctrl #(
  parameter int WIDTH         = 10,
  parameter int HEIGHT        = 10,
  parameter int COORD_BITS    = 8,
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int END_X         = WIDTH - 1,
  parameter int END_Y         = HEIGHT - 1,
  parameter int REPEAT_CYCLES = 0,
  parameter int COUNT_BITS    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      at_start,
  input  logic                      stop_player,
  input  logic [3:0]                player_direction,
  input  logic [WIDTH*HEIGHT-1:0]   maze,
  output logic [COORD_BITS-1:0]     player_x,
  output logic [COORD_BITS-1:0]     player_y,
  output logic                      at_end,
  output logic                      move_valid,
  output logic                      wall_hit,
  output logic [COUNT_BITS-1:0]     move_count
);

  localparam int CELLS    = WIDTH * HEIGHT;
  localparam int IDX_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int REP_BITS = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [COORD_BITS-1:0] X_MAX   = COORD_BITS'(WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX   = COORD_BITS'(HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] X_START = COORD_BITS'(START_X);
  localparam logic [COORD_BITS-1:0] Y_START = COORD_BITS'(START_Y);
  localparam logic [COORD_BITS-1:0] X_END   = COORD_BITS'(END_X);
  localparam logic [COORD_BITS-1:0] Y_END   = COORD_BITS'(END_Y);
  localparam logic [REP_BITS-1:0]   REP_LAST =
    REP_BITS'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam logic [IDX_BITS-1:0]   ROW_LEN = IDX_BITS'(WIDTH);

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              dir_prev;
  logic [REP_BITS-1:0]     rep_cnt;

  logic                    dir_valid;
  logic                    held;
  logic                    rep_fire;
  logic [REP_BITS-1:0]     rep_next;
  logic                    request;
  logic [COORD_BITS-1:0]   tgt_x;
  logic [COORD_BITS-1:0]   tgt_y;
  logic                    in_bounds;
  logic [IDX_BITS-1:0]     idx;
  logic                    blocked;
  logic                    reaches_goal;

  // Decode the request, the repeat timer and the target cell legality.
  always_comb begin
    dir_valid = (player_direction == DIR_UP)    ||
                (player_direction == DIR_DOWN)  ||
                (player_direction == DIR_RIGHT) ||
                (player_direction == DIR_LEFT);
    held      = dir_valid && (player_direction == dir_prev);

    // Repeat counter only runs while the same direction stays held.
    rep_fire = 1'b0;
    rep_next = '0;
    if ((REPEAT_CYCLES > 0) && held) begin
      if (rep_cnt == REP_LAST) rep_fire = 1'b1;
      else                     rep_next = rep_cnt + 1'b1;
    end

    request = dir_valid && ((player_direction != dir_prev) || rep_fire);

    // Edge checks happen before any subtraction/addition is used, so the
    // coordinates never wrap into a neighbouring row or column.
    tgt_x     = player_x;
    tgt_y     = player_y;
    in_bounds = 1'b0;
    case (player_direction)
      DIR_UP: begin
        in_bounds = (player_y != '0);
        tgt_y     = player_y - 1'b1;
      end
      DIR_DOWN: begin
        in_bounds = (player_y != Y_MAX);
        tgt_y     = player_y + 1'b1;
      end
      DIR_RIGHT: begin
        in_bounds = (player_x != X_MAX);
        tgt_x     = player_x + 1'b1;
      end
      DIR_LEFT: begin
        in_bounds = (player_x != '0);
        tgt_x     = player_x - 1'b1;
      end
      default: in_bounds = 1'b0;
    endcase

    idx          = in_bounds ? (IDX_BITS'(tgt_y) * ROW_LEN + IDX_BITS'(tgt_x)) : '0;
    blocked      = !in_bounds || maze[idx];
    reaches_goal = (tgt_x == X_END) && (tgt_y == Y_END);
  end

  // Game state, position, counters and one-cycle feedback pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      player_x   <= X_START;
      player_y   <= Y_START;
      at_end     <= 1'b0;
      move_valid <= 1'b0;
      wall_hit   <= 1'b0;
      move_count <= '0;
      dir_prev   <= '0;
      rep_cnt    <= '0;
    end else begin
      // Tracked every cycle so a key held through a freeze does not fire
      // as a fresh press when the freeze lifts.
      dir_prev   <= player_direction;
      move_valid <= 1'b0;
      wall_hit   <= 1'b0;
      if (at_start) begin
        state      <= IDLE;
        player_x   <= X_START;
        player_y   <= Y_START;
        at_end     <= 1'b0;
        move_count <= '0;
        rep_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= PLAY;
            rep_cnt <= '0;
          end
          PLAY: begin
            if (stop_player) begin
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_next;
              if (request) begin
                if (blocked) begin
                  wall_hit <= 1'b1;
                end else begin
                  player_x   <= tgt_x;
                  player_y   <= tgt_y;
                  move_valid <= 1'b1;
                  if (move_count != '1) move_count <= move_count + 1'b1;
                  if (reaches_goal) begin
                    state  <= DONE;
                    at_end <= 1'b1;
                  end
                end
              end
            end
          end
          DONE: begin
            rep_cnt <= '0;
          end
          default: begin
            state   <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
